// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding and widths.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;
  localparam logic [DIV_WIDTH-1:0] INT_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_nr_step.sv
// One non-restoring division step: takes the already-shifted {A,Q} and the divisor
// magnitude, returns the next {A,Q}. A is WIDTH+1 bits so its sign survives large divisors.
module div_nr_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] aq_sh,
  input  logic [WIDTH-1:0] m,
  output logic [2*WIDTH:0] aq_next
);

  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] a_new;

  always_comb begin
    a_sh  = aq_sh[2*WIDTH:WIDTH];
    a_new = a_sh[WIDTH] ? (a_sh + {1'b0, m}) : (a_sh - {1'b0, m});
    // The shift vacated Q[0], so the new quotient bit can simply be OR-ed in.
    aq_next = {a_new, aq_sh[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~a_new[WIDTH]}};
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential signed divider controller: magnitude capture, WIDTH non-restoring steps,
// remainder correction and sign restore. Define DIV_REMAINDER_EN to expose data_remainder.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [2*WIDTH:0] aq_q;
  logic [2*WIDTH:0] aq_step;
  logic [WIDTH-1:0] m_q;
  logic             neg_q_q;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   a_fin;
  logic             div0, ovf, start_ok;

  assign a_abs    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_abs    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign div0     = (data_operandB == '0);
  assign ovf      = (data_operandA == MIN_VAL) && (data_operandB == '1);
  assign start_ok = ctrl_DIV && ((state_q == IDLE) || (state_q == DONE));
  assign a_fin    = aq_q[2*WIDTH] ? (aq_q[2*WIDTH:WIDTH] + {1'b0, m_q}) : aq_q[2*WIDTH:WIDTH];

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .aq_sh   ({aq_q[2*WIDTH-1:0], 1'b0}),
    .m       (m_q),
    .aq_next (aq_step)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (ctrl_DIV)           state_d = (div0 || ovf) ? DONE : RUN;
        else                    state_d = IDLE;
      end
      RUN:     if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DIV_REMAINDER_EN
  logic neg_a_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neg_a_q        <= 1'b0;
      data_remainder <= '0;
    end else if (start_ok) begin
      neg_a_q <= data_operandA[WIDTH-1];
      if (div0 || ovf) data_remainder <= '0;
    end else if (state_q == FIX) begin
      data_remainder <= neg_a_q ? -a_fin[WIDTH-1:0] : a_fin[WIDTH-1:0];
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q          <= '0;
      aq_q           <= '0;
      m_q            <= '0;
      neg_q_q        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Outputs track the next state so RDY/busy line up with DONE and RUN/FIX.
      data_resultRDY <= (state_d == DONE);
      busy           <= (state_d == RUN) || (state_d == FIX);
      case (state_q)
        IDLE, DONE: begin
          if (ctrl_DIV) begin
            m_q     <= b_abs;
            aq_q    <= {{(WIDTH+1){1'b0}}, a_abs};
            neg_q_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            cnt_q   <= '0;
            if (div0) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else if (ovf) begin
              data_result    <= MIN_VAL;
              data_exception <= 1'b1;
            end else begin
              data_exception <= 1'b0;
            end
          end
        end
        RUN: begin
          aq_q  <= aq_step;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          aq_q[2*WIDTH:WIDTH] <= a_fin;
          data_result <= neg_q_q ? -aq_q[WIDTH-1:0] : aq_q[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: vector table, corner sequences and random ops
// against an arithmetic reference. Remainder checks are active when DIV_REMAINDER_EN is defined.
module tb_div_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int errors = 0;
  int checks = 0;

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a, b, q;
    logic        e;
    logic [31:0] r;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // C-style truncating division on plain integers.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic e, output logic [31:0] r);
    int     ai, bi;
    longint sa, sb;
    ai = a; bi = b;
    sa = ai; sb = bi;
    if (sb == 0) begin
      q = 32'h0; e = 1'b1; r = 32'h0;
    end else if (sa == -64'sd2147483648 && sb == -1) begin
      q = 32'h8000_0000; e = 1'b1; r = 32'h0;
    end else begin
      q = 32'(sa / sb); e = 1'b0; r = 32'(sa % sb);
    end
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a; data_operandB = b; ctrl_DIV = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_rdy(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    while (!data_resultRDY && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clock);
      lat++;
    end
    if (lat >= 100) check("rdy_timeout", {63'd0, data_resultRDY}, 64'd1);
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] q, input logic e,
                               input logic [31:0] r);
    check({tag, "_result"}, {32'd0, data_result}, {32'd0, q});
    check({tag, "_exc"}, {63'd0, data_exception}, {63'd0, e});
`ifdef DIV_REMAINDER_EN
    check({tag, "_rem"}, {32'd0, data_remainder}, {32'd0, r});
`else
    if (r !== r) $display("unreachable");
`endif
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic e, input logic [31:0] r);
    int lat, bc;
    start_op(a, b);
    wait_rdy(lat, bc);
    check({tag, "_latency"}, 64'(lat), e ? 64'd0 : 64'd33);
    check({tag, "_busy_cycles"}, 64'(bc), e ? 64'd0 : 64'd33);
    check_outputs(tag, q, e, r);
    @(negedge clock);
    check({tag, "_rdy_width"}, {63'd0, data_resultRDY}, 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int lat, bc, rdy_seen;
    logic [31:0] ra, rb, rq, rr;
    logic        re;

    vecs.push_back('{32'd100,       32'd7,         32'd14,        1'b0, 32'd2});
    vecs.push_back('{-32'sd100,     32'd7,         32'hFFFF_FFF2, 1'b0, 32'hFFFF_FFFE});
    vecs.push_back('{32'd5,         32'd0,         32'd0,         1'b1, 32'd0});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd0});
    vecs.push_back('{32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0, 32'd0});
    vecs.push_back('{32'd9,         -32'sd3,       32'hFFFF_FFFD, 1'b0, 32'd0});
    vecs.push_back('{32'd7,         32'd100,       32'd0,         1'b0, 32'd7});
    vecs.push_back('{-32'sd7,       -32'sd2,       32'd3,         1'b0, 32'hFFFF_FFFF});
    vecs.push_back('{32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 32'hFFFF_FFFF});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 32'd1,         1'b0, 32'd0});
    vecs.push_back('{32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 1'b0, 32'd0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 32'd0});
    vecs.push_back('{32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 32'd0});
    vecs.push_back('{32'd0,         32'd5,         32'd0,         1'b0, 32'd0});

    reset = 1'b0; ctrl_DIV = 1'b0; data_operandA = '0; data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset_result", {32'd0, data_result}, 64'd0);
    check("reset_exc", {63'd0, data_exception}, 64'd0);
    check("reset_rdy", {63'd0, data_resultRDY}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    reset = 1'b1;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].e, vecs[i].r);

    // Reset mid-RUN aborts without a completion pulse.
    start_op(32'd1000, 32'd3);
    repeat (8) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_result", {32'd0, data_result}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    rdy_seen = 0;
    repeat (50) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("abort_no_rdy", 64'(rdy_seen), 64'd0);
    do_op("after_abort", 32'd9, -32'sd3, 32'hFFFF_FFFD, 1'b0, 32'd0);

    // Start re-pulsed while running is ignored.
    start_op(32'd100, 32'd7);
    repeat (4) @(negedge clock);
    data_operandA = 32'd50; data_operandB = 32'd5; ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_rdy(lat, bc);
    check("repulse_latency", 64'(lat), 64'd28);
    check_outputs("repulse", 32'd14, 1'b0, 32'd2);

    // ctrl_DIV held across DONE: second op starts with no idle cycle.
    @(negedge clock);
    data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    @(posedge clock);
    @(negedge clock);
    data_operandA = 32'd1000; data_operandB = -32'sd3;
    wait_rdy(lat, bc);
    check("b2b_first_latency", 64'(lat), 64'd33);
    check_outputs("b2b_first", 32'd14, 1'b0, 32'd2);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    check("b2b_second_busy", {63'd0, busy}, 64'd1);
    wait_rdy(lat, bc);
    check("b2b_pulse_gap", 64'(lat + 1), 64'd34);
    check_outputs("b2b_second", 32'hFFFF_FEB3, 1'b0, 32'd1);
    @(negedge clock);
    check("b2b_no_third", {62'd0, busy, data_resultRDY}, 64'd0);

    for (int n = 0; n < 150; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = -32'($urandom_range(0, 15));
        2:       begin ra = 32'h8000_0000; rb = $urandom; end
        default: rb = $urandom;
      endcase
      ref_div(ra, rb, rq, re, rr);
      do_op($sformatf("rnd%0d", n), ra, rb, rq, re, rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
